viterbi_traceback: RTL
======================

// Module: viterbi_traceback
// PURPOSE
//  Survivor-memory and traceback stage of the WiFi PHY hard-decision Viterbi decoder.
//  Sits directly downstream of the ACS array: stores one survivor bit per trellis state per step.
//  The frame is tail-terminated, so traceback starts from state 0 at frame end.
//  Output is the decoded bit stream in original order, tail bits removed, over a valid/ready handshake.
// PARAMETERS
//  K          7    constraint length; NS = 2**(K-1) states (64 at default)
//  MAX_STEPS  512  survivor-memory depth in trellis steps (max frame length incl. tail)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous, active-high reset
//  surv_valid  in   1        surv_vec carries one trellis step
//  surv_vec    in   NS       bit s = ACS Survivor of state s (1 = predecessor with LSB 1)
//  surv_last   in   1        qualifies the final (tail) step of the frame
//  in_ready    out  1        stage accepts survivor vectors
//  dec_bit     out  1        decoded data bit
//  dec_valid   out  1        dec_bit valid
//  dec_ready   in   1        consumer accepts dec_bit
//  dec_last    out  1        with dec_valid: last data bit of frame
//  frame_done  out  1        1-cycle pulse when frame fully output (or empty frame dropped)
//  overflow    out  1        sticky: frame truncated at MAX_STEPS; cleared on first step of next frame
//  busy        out  1        high in TRACE or OUTPUT
// BEHAVIOUR
//  Trellis convention: next state s' = {u, s[K-2:1]}; predecessor of s' = {s'[K-3:0], surv_vec[s']};
//   decoded bit of step t = MSB (bit K-2) of state at step t.
//  Reset: FSM=FILL, wr_ptr=0, all outputs 0; in_ready rises first cycle after rst deasserts.
//   Reset mid-frame aborts; stored survivors are discarded, no outputs emitted.
//  FILL: in_ready=1. On surv_valid: mem[wr_ptr]<=surv_vec; wr_ptr++.
//   surv_valid&surv_last -> len=wr_ptr+1, go TRACE.
//   surv_valid at wr_ptr==MAX_STEPS-1 without surv_last -> treated as last; overflow<=1.
//  TRACE: in_ready=0; tb_state starts at 0; t runs len-1 down to 0, one step per cycle:
//   dec_mem[t]<=tb_state[K-2]; tb_state<={tb_state[K-3:0], mem[t][tb_state]}.
//   Latency exactly len cycles. Then:
//    - len>K-1 -> go OUTPUT, idx=0.
//    - len<=K-1 -> pulse frame_done, go FILL, no bits output.
//  OUTPUT: dec_valid=1, dec_bit=dec_mem[idx]; idx++ on dec_valid&dec_ready.
//   dec_last=1 when idx==len-K (last K-1 tail bits never output).
//   Last handshake -> frame_done pulse next cycle, dec_valid=0, wr_ptr=0, go FILL.
//   dec_bit/dec_last held stable while dec_valid&!dec_ready.
//  in_ready is 0 throughout TRACE/OUTPUT. surv_valid there is a protocol violation, ignored.
//  Throughput: len store + len trace + (len-K+1) output cycles per frame; no overlap between frames.
//  Widths: wr_ptr/idx/t are clog2(MAX_STEPS) bits; no wrap, since pointer never exceeds MAX_STEPS-1.
// TESTING
//  (K=3, MAX_STEPS=16 unless noted; off-path surv_vec bits randomized)
//  T1 data 1,0,1,1 + tail 0,0: steps with surv_vec[2]=0,[1]=0,[2]=1,[3]=0,[1]=1,[0]=1 (last on 6th)
//     -> dec_bit 1,0,1,1; dec_last on 4th; frame_done 1 cycle after; TRACE lasts 6 cycles.
//  T2 T1 with dec_ready toggling 1/0 each cycle -> same 4 bits, each held stable while stalled,
//     no duplicates or drops.
//  T3 2-step frame (len=K-1) -> no dec_valid; frame_done pulses; in_ready=1 next cycle.
//  T4 17 steps without surv_last -> overflow=1 after 16th; 16-step traceback; 17th step not accepted
//     (in_ready=0); next frame's first step clears overflow.
//  T5 rst asserted mid-OUTPUT after 2 bits -> dec_valid/busy=0 immediately;
//     next frame T1 decodes correctly.
//  T6 K=7 default: random 200-bit payload + 6 zero tail; survivors from golden encoder + ACS model
//     -> output equals payload bit-exact.

Source files
------------

// File: rtl/viterbi_traceback_if.sv
// Survivor-in / decoded-bit-out handshake bundle for the Viterbi traceback stage.
// master = ACS producer plus decoded-bit consumer; slave = traceback stage.
interface viterbi_traceback_if #(
    parameter int NS = 64
);
    logic          surv_valid;
    logic [NS-1:0] surv_vec;
    logic          surv_last;
    logic          in_ready;
    logic          dec_bit;
    logic          dec_valid;
    logic          dec_ready;
    logic          dec_last;

    modport master (
        output surv_valid, surv_vec, surv_last, dec_ready,
        input  in_ready, dec_bit, dec_valid, dec_last
    );

    modport slave (
        input  surv_valid, surv_vec, surv_last, dec_ready,
        output in_ready, dec_bit, dec_valid, dec_last
    );
endinterface

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for a tail-terminated hard-decision Viterbi decoder.
// Frames are stored, traced back from state 0, then emitted in original order minus the tail.
module viterbi_traceback #(
    parameter int K         = 7,
    parameter int MAX_STEPS = 512
) (
    input  logic                clk,
    input  logic                rst,
    viterbi_traceback_if.slave  bus,
    output logic                frame_done,
    output logic                overflow,
    output logic                busy
);
    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int AW = $clog2(MAX_STEPS);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {FILL, TRACE, OUTPUT} state_t;

    state_t          state;
    logic [NS-1:0]   mem [MAX_STEPS];
    logic [MAX_STEPS-1:0] dec_mem;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   t;
    logic [AW-1:0]   idx;
    logic [LW-1:0]   len;
    logic [SW-1:0]   tb_state;

    logic            accept;
    logic            at_end;
    logic            surv_bit;
    logic [LW-1:0]   last_idx;

    assign accept   = (state == FILL) && bus.in_ready && bus.surv_valid;
    assign at_end   = (wr_ptr == AW'(MAX_STEPS - 1));
    assign surv_bit = mem[t][tb_state];
    assign last_idx = len - LW'(K);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= bus.surv_vec;
    end

    // Decoded bits land in step order while tracing runs backwards.
    always_ff @(posedge clk) begin
        if (state == TRACE)
            dec_mem[t] <= tb_state[SW-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            wr_ptr        <= '0;
            t             <= '0;
            idx           <= '0;
            len           <= '0;
            tb_state      <= '0;
            bus.in_ready  <= 1'b0;
            bus.dec_valid <= 1'b0;
            bus.dec_bit   <= 1'b0;
            bus.dec_last  <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (at_end && !bus.surv_last)
                            overflow <= 1'b1;
                        else if (wr_ptr == '0)
                            overflow <= 1'b0;
                        // A full memory closes the frame as if surv_last had been seen.
                        if (bus.surv_last || at_end) begin
                            state        <= TRACE;
                            len          <= LW'(wr_ptr) + 1'b1;
                            t            <= wr_ptr;
                            tb_state     <= '0;
                            wr_ptr       <= '0;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                end
                TRACE: begin
                    tb_state <= {tb_state[SW-2:0], surv_bit};
                    if (t != '0) begin
                        t <= t - 1'b1;
                    end else if (len > LW'(K - 1)) begin
                        // Step 0's bit is still being written, so forward it directly.
                        state         <= OUTPUT;
                        idx           <= '0;
                        bus.dec_valid <= 1'b1;
                        bus.dec_bit   <= tb_state[SW-1];
                        bus.dec_last  <= (len == LW'(K));
                    end else begin
                        state        <= FILL;
                        frame_done   <= 1'b1;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.dec_valid && bus.dec_ready) begin
                        if (bus.dec_last) begin
                            state         <= FILL;
                            bus.dec_valid <= 1'b0;
                            bus.dec_last  <= 1'b0;
                            frame_done    <= 1'b1;
                            busy          <= 1'b0;
                            bus.in_ready  <= 1'b1;
                        end else begin
                            idx          <= idx + 1'b1;
                            bus.dec_bit  <= dec_mem[idx + 1'b1];
                            bus.dec_last <= (LW'(idx) + LW'(1) == last_idx);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
